// File: rtl/bomb_pkg.sv
// Shared constants and encodings for the bomb request stage.
package bomb_pkg;

    localparam int GRID_DEFAULT           = 10;
    localparam int COOLDOWN_TICKS_DEFAULT = 2;
    localparam int CNT_W_DEFAULT          = 8;
    localparam int COORD_W                = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } req_state_e;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        B_WINS  = 2'd1,
        A_WINS  = 2'd2,
        DRAW    = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        ARMED     = 2'b01,
        TICKING   = 2'b10,
        EXPLODING = 2'b11
    } cell_e;

endpackage

// File: rtl/bomb_request_if.sv
// Player-input / request-output bundle between the game logic and bomb_request.
interface bomb_request_if #(
    parameter int GRID  = bomb_pkg::GRID_DEFAULT,
    parameter int CNT_W = bomb_pkg::CNT_W_DEFAULT
);
    logic                          bomb_tick;
    logic                          btnA, btnB;
    logic [bomb_pkg::COORD_W-1:0]  playerAx, playerAy, playerBx, playerBy;
    logic [1:0]                    healthA, healthB;
    logic [1:0]                    game_state;
    logic [GRID*GRID-1:0]          i_curBombMap_0, i_curBombMap_1;
    logic [bomb_pkg::COORD_W-1:0]  bombA_x, bombA_y, bombB_x, bombB_y;
    logic                          bombA_v, bombB_v;
    logic                          o_readyA, o_readyB;
    logic [CNT_W-1:0]              o_placedA, o_placedB;

    modport master (
        output bomb_tick, btnA, btnB, playerAx, playerAy, playerBx, playerBy,
               healthA, healthB, game_state, i_curBombMap_0, i_curBombMap_1,
        input  bombA_x, bombA_y, bombB_x, bombB_y, bombA_v, bombB_v,
               o_readyA, o_readyB, o_placedA, o_placedB
    );

    modport slave (
        input  bomb_tick, btnA, btnB, playerAx, playerAy, playerBx, playerBy,
               healthA, healthB, game_state, i_curBombMap_0, i_curBombMap_1,
        output bombA_x, bombA_y, bombB_x, bombB_y, bombA_v, bombB_v,
               o_readyA, o_readyB, o_placedA, o_placedB
    );
endinterface

// File: rtl/bomb_req_player.sv
// One player's request path: button sync/edge detect, IDLE/PENDING/COOLDOWN
// FSM, cooldown counter and saturating placed-bomb counter.
module bomb_req_player
    import bomb_pkg::*;
#(
    parameter int GRID           = GRID_DEFAULT,
    parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bomb_tick,
    input  logic               btn,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         health,
    input  logic [1:0]         game_state,
    input  logic               busy,
    input  logic               block,
    output logic               accept,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic               bomb_v,
    output logic               ready,
    output logic [CNT_W-1:0]   placed
);
    localparam int CD_W = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    req_state_e      state, state_nxt;
    logic [2:0]      sync;
    logic            press, consume, cancel;
    logic [CD_W-1:0] cd;

    // sync[1:0] is the two-flop synchroniser, sync[2] the previous level for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], btn};
    end

    assign press   = sync[1] & ~sync[2];
    assign accept  = (state == IDLE) && press && (health != 2'd0) &&
                     (game_state == RUNNING) && (int'(x) < GRID) && (int'(y) < GRID) &&
                     !busy && !block;
    // a tick in the same cycle as game over still consumes the request
    assign consume = (state == PENDING) && bomb_tick;
    assign cancel  = (state == PENDING) && !bomb_tick && (game_state != RUNNING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = PENDING;
            PENDING: begin
                if (consume)     state_nxt = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
                else if (cancel) state_nxt = IDLE;
            end
            COOLDOWN: if (bomb_tick && cd == CD_W'(1)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bomb_v = 1'b0;
        ready  = 1'b0;
        case (state)
            IDLE:    ready  = 1'b1;
            PENDING: bomb_v = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bomb_x <= '0;
            bomb_y <= '0;
            cd     <= '0;
            placed <= '0;
        end else begin
            if (accept) begin
                bomb_x <= x;
                bomb_y <= y;
            end
            if (consume) begin
                cd <= CD_W'(COOLDOWN_TICKS);
                if (placed != '1) placed <= placed + 1'b1;
            end else if (state == COOLDOWN && bomb_tick) begin
                cd <= cd - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bomb_request.sv
// Two-player bomb request stage: map occupancy lookup, same-cell conflict
// resolution (A has priority) and the two per-player request engines.
module bomb_request
    import bomb_pkg::*;
#(
    parameter int GRID           = GRID_DEFAULT,
    parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    bomb_request_if.slave bus
);
    localparam int MAP_W = GRID * GRID;

    function automatic logic cell_busy(input logic [MAP_W-1:0]   m0,
                                       input logic [MAP_W-1:0]   m1,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        logic hit;
        int   idx;
        hit = 1'b0;
        idx = GRID * int'(x) + int'(y);
        for (int i = 0; i < MAP_W; i++)
            if (i == idx) hit = ({m1[i], m0[i]} != EMPTY);
        return hit;
    endfunction

    logic busy_a, busy_b, block_b, accept_a;
    // B's accept has no consumer; only A's feeds the conflict check
    logic unused_accept_b;

    assign busy_a = cell_busy(bus.i_curBombMap_0, bus.i_curBombMap_1, bus.playerAx, bus.playerAy);
    assign busy_b = cell_busy(bus.i_curBombMap_0, bus.i_curBombMap_1, bus.playerBx, bus.playerBy);

    assign block_b = (bus.bombA_v && bus.bombA_x == bus.playerBx && bus.bombA_y == bus.playerBy) ||
                     (accept_a   && bus.playerAx == bus.playerBx && bus.playerAy == bus.playerBy);

    bomb_req_player #(.GRID(GRID), .COOLDOWN_TICKS(COOLDOWN_TICKS), .CNT_W(CNT_W)) u_a (
        .clk        (clk),
        .rst        (rst),
        .bomb_tick  (bus.bomb_tick),
        .btn        (bus.btnA),
        .x          (bus.playerAx),
        .y          (bus.playerAy),
        .health     (bus.healthA),
        .game_state (bus.game_state),
        .busy       (busy_a),
        .block      (1'b0),
        .accept     (accept_a),
        .bomb_x     (bus.bombA_x),
        .bomb_y     (bus.bombA_y),
        .bomb_v     (bus.bombA_v),
        .ready      (bus.o_readyA),
        .placed     (bus.o_placedA)
    );

    bomb_req_player #(.GRID(GRID), .COOLDOWN_TICKS(COOLDOWN_TICKS), .CNT_W(CNT_W)) u_b (
        .clk        (clk),
        .rst        (rst),
        .bomb_tick  (bus.bomb_tick),
        .btn        (bus.btnB),
        .x          (bus.playerBx),
        .y          (bus.playerBy),
        .health     (bus.healthB),
        .game_state (bus.game_state),
        .busy       (busy_b),
        .block      (block_b),
        .accept     (unused_accept_b),
        .bomb_x     (bus.bombB_x),
        .bomb_y     (bus.bombB_y),
        .bomb_v     (bus.bombB_v),
        .ready      (bus.o_readyB),
        .placed     (bus.o_placedB)
    );

endmodule

// File: tb/tb_bomb_request.sv
// Scoreboard bench for bomb_request: a request-level model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_bomb_request;
    localparam int GRID  = 10;
    localparam int CD    = 2;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]       x;
        logic [3:0]       y;
        logic             v;
        logic             ready;
        logic [CNT_W-1:0] placed;
    } pexp_t;

    typedef struct packed {
        pexp_t a;
        pexp_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bomb_request_if #(.GRID(GRID), .CNT_W(CNT_W)) bus ();

    bomb_request #(.GRID(GRID), .COOLDOWN_TICKS(CD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Request-level model: a pending request, remaining cooldown ticks,
    // consumed count, and the recent sampled button levels per player.
    bit         m_pend[2];
    int         m_cool[2];
    int         m_placed[2];
    logic [3:0] m_x[2], m_y[2];
    bit         m_hist[2][3];

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_cool[p] = 0; m_placed[p] = 0;
            m_x[p] = '0; m_y[p] = '0;
            for (int k = 0; k < 3; k++) m_hist[p][k] = 0;
        end
    endfunction

    function automatic pexp_t expect_p(int p);
        pexp_t e;
        e.x      = m_x[p];
        e.y      = m_y[p];
        e.v      = m_pend[p];
        e.ready  = !m_pend[p] && (m_cool[p] == 0);
        e.placed = CNT_W'(m_placed[p]);
        return e;
    endfunction

    function automatic bit place_ok(logic [3:0] x, logic [3:0] y, logic [1:0] hp);
        int idx;
        if (hp == 0 || bus.game_state != 0 || x >= GRID || y >= GRID) return 0;
        idx = GRID * int'(x) + int'(y);
        return !(bus.i_curBombMap_0[idx] || bus.i_curBombMap_1[idx]);
    endfunction

    function automatic void model_edge();
        bit         acc[2];
        bit         press[2];
        bit         btn[2];
        bit         a_pend_old, block_b;
        logic [3:0] ax_old, ay_old;
        if (rst) begin
            model_reset();
            return;
        end
        btn[0] = bus.btnA;
        btn[1] = bus.btnB;
        for (int p = 0; p < 2; p++) press[p] = m_hist[p][1] && !m_hist[p][2];
        a_pend_old = m_pend[0]; ax_old = m_x[0]; ay_old = m_y[0];
        acc[0] = !m_pend[0] && m_cool[0] == 0 && press[0] &&
                 place_ok(bus.playerAx, bus.playerAy, bus.healthA);
        block_b = (a_pend_old && ax_old == bus.playerBx && ay_old == bus.playerBy) ||
                  (acc[0] && bus.playerAx == bus.playerBx && bus.playerAy == bus.playerBy);
        acc[1] = !m_pend[1] && m_cool[1] == 0 && press[1] && !block_b &&
                 place_ok(bus.playerBx, bus.playerBy, bus.healthB);
        for (int p = 0; p < 2; p++) begin
            if (m_pend[p]) begin
                if (bus.bomb_tick) begin
                    m_pend[p] = 0;
                    if (m_placed[p] < SAT) m_placed[p]++;
                    m_cool[p] = CD;
                end else if (bus.game_state != 0) begin
                    m_pend[p] = 0;
                end
            end else if (m_cool[p] > 0) begin
                if (bus.bomb_tick) m_cool[p]--;
            end else if (acc[p]) begin
                m_pend[p] = 1;
                m_x[p] = (p == 0) ? bus.playerAx : bus.playerBx;
                m_y[p] = (p == 0) ? bus.playerAy : bus.playerBy;
            end
            m_hist[p][2] = m_hist[p][1];
            m_hist[p][1] = m_hist[p][0];
            m_hist[p][0] = btn[p];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        exp_q.push_back({expect_p(0), expect_p(1)});
        #1;
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    // asserted mid-cycle so the following negedge sees the async clear
    task automatic do_reset(int n);
        rst = 1'b1;
        model_reset();
        exp_q.delete();
        exp_q.push_back({expect_p(0), expect_p(1)});
        steps(n);
        rst = 1'b0;
    endtask

    task automatic pulse_a();
        bus.btnA = 1'b1; step(); bus.btnA = 1'b0; steps(4);
    endtask

    task automatic tick();
        bus.bomb_tick = 1'b1; step(); bus.bomb_tick = 1'b0; step();
    endtask

    task automatic compare_p(string name, pexp_t got, pexp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got x=%0d y=%0d v=%0b ready=%0b placed=%0d want x=%0d y=%0d v=%0b ready=%0b placed=%0d",
                     name, $time, got.x, got.y, got.v, got.ready, got.placed,
                     want.x, want.y, want.v, want.ready, want.placed);
        end
    endtask

    initial begin
        exp_t  e;
        pexp_t ga, gb;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ga = {bus.bombA_x, bus.bombA_y, bus.bombA_v, bus.o_readyA, bus.o_placedA};
                gb = {bus.bombB_x, bus.bombB_y, bus.bombB_v, bus.o_readyB, bus.o_placedB};
                compare_p("playerA", ga, e.a);
                compare_p("playerB", gb, e.b);
            end
        end
    end

    task automatic rand_map();
        for (int i = 0; i < GRID * GRID; i++) begin
            bus.i_curBombMap_0[i] = ($urandom_range(0, 9) == 0);
            bus.i_curBombMap_1[i] = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.bomb_tick = 0; bus.btnA = 0; bus.btnB = 0;
        bus.playerAx = 4'd3; bus.playerAy = 4'd4; bus.playerBx = 4'd9; bus.playerBy = 4'd9;
        bus.healthA = 2'd3; bus.healthB = 2'd3; bus.game_state = 2'd0;
        bus.i_curBombMap_0 = '0; bus.i_curBombMap_1 = '0;
        #1 rst = 1'b1;
        model_reset();
        steps(3);
        rst = 1'b0;

        // basic placement, consumption, cooldown with an ignored press
        pulse_a(); steps(2); tick();
        bus.btnA = 1'b1; step(); bus.btnA = 1'b0; steps(4);
        tick(); steps(2); tick();
        bus.playerAx = 4'd5; bus.playerAy = 4'd5; pulse_a();
        tick(); tick(); tick(); steps(2);

        // same-cell conflict: A wins
        bus.playerAx = 4'd2; bus.playerAy = 4'd2; bus.playerBx = 4'd2; bus.playerBy = 4'd2;
        bus.btnA = 1'b1; bus.btnB = 1'b1; step(); bus.btnA = 1'b0; bus.btnB = 1'b0; steps(5);
        // B presses A's pending cell
        bus.btnB = 1'b1; step(); bus.btnB = 1'b0; steps(5);
        tick(); tick(); tick();
        bus.playerBx = 4'd9; bus.playerBy = 4'd9;

        // rejections
        bus.playerAx = 4'd3; bus.playerAy = 4'd4; bus.i_curBombMap_0[34] = 1'b1; pulse_a();
        bus.i_curBombMap_0 = '0; bus.i_curBombMap_1[34] = 1'b1; pulse_a();
        bus.i_curBombMap_1 = '0; bus.healthA = 2'd0; pulse_a();
        bus.healthA = 2'd3; bus.game_state = 2'd2; pulse_a();
        bus.game_state = 2'd0; bus.playerAx = 4'd12; pulse_a();
        bus.playerAx = 4'd3; bus.playerAy = 4'd10; pulse_a();
        bus.playerAy = 4'd4;

        // game over cancels a pending request; tick wins over game over
        pulse_a(); bus.game_state = 2'd1; steps(2); bus.game_state = 2'd0; steps(2);
        pulse_a(); bus.game_state = 2'd3; bus.bomb_tick = 1'b1; step();
        bus.bomb_tick = 1'b0; bus.game_state = 2'd0; tick(); tick();

        // press coincident with tick while idle, then async reset mid-pending
        bus.btnA = 1'b1; step(); bus.btnA = 1'b0; steps(1); bus.bomb_tick = 1'b1; step();
        bus.bomb_tick = 1'b0; steps(2);
        do_reset(2); steps(3); pulse_a(); tick(); tick(); tick();

        // drive the placed counter into saturation
        bus.bomb_tick = 1'b1;
        repeat (270) begin
            bus.btnA = 1'b1; step(); bus.btnA = 1'b0; steps(5);
        end
        bus.bomb_tick = 1'b0; steps(3);

        // randomized traffic
        do_reset(2);
        rand_map();
        for (int c = 0; c < 1500; c++) begin
            bus.bomb_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) bus.btnA = ~bus.btnA;
            if ($urandom_range(0, 3) == 0) bus.btnB = ~bus.btnB;
            if ($urandom_range(0, 7) == 0) begin
                bus.playerAx = 4'($urandom_range(0, 11));
                bus.playerAy = 4'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.playerBx = bus.playerAx; bus.playerBy = bus.playerAy;
                end else begin
                    bus.playerBx = 4'($urandom_range(0, 11));
                    bus.playerBy = 4'($urandom_range(0, 11));
                end
            end
            bus.healthA    = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            bus.healthB    = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            bus.game_state = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (c % 25 == 0) rand_map();
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else step();
        end

        bus.bomb_tick = 1'b0;
        step();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_request.md
Name: bomb_request

Overview:
- Upstream stage of the bomb map updater: turns raw player bomb buttons into the per-player placement requests (bombA_x/y/v, bombB_x/y/v) that the updater samples on its 1 Hz tick.
- Synchronises and edge-detects the buttons, and validates each request against health, game state and current map occupancy.
- Holds each accepted request stable until the tick consumes it, then enforces a per-player cooldown.
- Resolves same-cell conflicts between the two players.

Parameters:
- GRID, 10, board dimension; map bit index = GRID*x + y.
- COOLDOWN_TICKS, 2, bomb ticks a player waits after a placement is consumed before the next press is accepted.
- CNT_W, 8, width of the saturating placed-bomb counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bomb_tick  in  1  one-clk pulse coincident with the bomb updater's sampling edge.
- btnA, btnB  in  1  raw asynchronous player bomb buttons.
- playerAx, playerAy, playerBx, playerBy  in  4  player grid coordinates.
- healthA, healthB  in  2  current player health.
- game_state  in  2  0 = running, nonzero = game over.
- i_curBombMap_0, i_curBombMap_1  in  100  current bomb map, 2 bits per cell.
- bombA_x, bombA_y, bombB_x, bombB_y  out  4  latched request coordinates.
- bombA_v, bombB_v  out  1  request valid.
- o_readyA, o_readyB  out  1  player FSM is in IDLE.
- o_placedA, o_placedB  out  CNT_W  count of consumed placements, saturating.

Behaviour:
- Reset (async, any state): every output 0 except o_readyA/B = 1; FSMs go to IDLE; synchronisers, cooldown counters and counters clear.
- Button path: 2-flop synchroniser, then rising-edge detect, giving a one-clk press pulse. Press-to-accept latency is 3 clk. A held button produces exactly one press.
- Per-player FSM with states IDLE, PENDING, COOLDOWN:
  - IDLE -> PENDING on a press when all of these hold:
    - health != 0
    - game_state == 0
    - x < GRID and y < GRID
    - map bits {_1,_0} at GRID*x+y are 00
    - conflict rule passes
  - On accept: latch x,y; v = 1 from the next clk.
  - A press failing any check is dropped: stay IDLE, no side effect.
- PENDING:
  - x, y, v held stable; presses ignored.
  - On bomb_tick: v = 0 next clk, o_placed increments (saturating at all-ones), cooldown loads COOLDOWN_TICKS, go to COOLDOWN. If COOLDOWN_TICKS == 0, go straight to IDLE.
  - game_state becoming nonzero while PENDING with no tick in the same cycle: cancel to IDLE, v = 0, counter unchanged.
  - Tick and game-over in the same cycle: the tick wins (counts as consumed).
- COOLDOWN:
  - Decrement on each bomb_tick; at the tick that takes the count to 0, go to IDLE.
  - Presses ignored. Outputs x, y keep their last values; v = 0.
- Conflict rule: B's press is rejected if its cell equals A's cell when A is PENDING, or when A is accepting in the same cycle. A always has priority. A is never rejected for B's sake.
- Press and bomb_tick in the same cycle while IDLE: accept the press. The request becomes PENDING and waits for the next tick; it is not consumed by the current tick.
- o_ready = (state == IDLE), registered with the state.
- Map occupancy is checked only at accept time. A cell that becomes occupied later does not cancel a PENDING request.

Decomposition:
- Shared package bomb_pkg holds:
  - GRID, COOLDOWN_TICKS defaults
  - state encoding: IDLE = 2'd0, PENDING = 2'd1, COOLDOWN = 2'd2
  - game_state encodings: RUNNING = 0, B_WINS = 1, A_WINS = 2, DRAW = 3
  - cell encodings: EMPTY = 00, ARMED = 01, TICKING = 10, EXPLODING = 11
- Sub-module bomb_req_player, instanced twice, contains: synchroniser, edge detect, FSM, cooldown counter and placed counter.
- It takes an external `block` input, driven by the top-level conflict logic (0 for A).
- The top level also performs the map-occupancy lookup per player.

Test Plan:
- Reset, A at (3,4), health 3, empty map; pulse btnA. Expect: bombA_v = 1, x = 3, y = 4 exactly 3 clk after the press; held through bomb_tick; v = 0 the clk after the tick; o_placedA = 1.
- After consumption with COOLDOWN_TICKS = 2: press at tick+1 ignored; o_readyA = 0 until the 2nd subsequent tick; then a press at (5,5) yields v = 1.
- A and B both at (2,2), both pressed in the same clk. Expect: bombA_v = 1, bombB_v = 0, o_readyB = 1, o_placedB stays 0.
- Rejection cases, each with no v asserted:
  - map bit 34 of _0 = 1 with A pressing at (3,4)
  - healthA = 0
  - game_state = 2
  - playerAx = 12
- A PENDING, game_state goes to 1 without a tick: bombA_v = 0 next clk, FSM back to IDLE, o_placedA unchanged.
- Assert rst mid-PENDING: bombA_v drops immediately (async), o_placedA = 0, o_readyA = 1; a press 3 clk after rst deassertion is accepted normally.
